// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: stall, flush and bubble control for load-use
// hazards, taken branches, jumps, multi-cycle ops with timeout, and drain-to-halt.
//
// state  | meaning
// RUN    | normal issue; resolves halt/branch/mc/stall/jump by priority
// MCWAIT | multi-cycle op in EX; front end and EX frozen until done or timeout
// DRAIN  | halt accepted; injecting bubbles while older instructions retire
// HALT   | pipeline parked; leaves when halt_req drops

module pipe_seq_ctrl #(
  parameter int MC_TIMEOUT   = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_stall,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        mc_start,
  input  logic        mc_done,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic [1:0]  state,
  output logic        halted,
  output logic        mc_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MCWAIT = 2'd1,
    DRAIN  = 2'd2,
    HALT   = 2'd3
  } seqState_t;

  localparam logic [7:0] MC_LOAD    = 8'(MC_TIMEOUT - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  seqState_t  curState, nextState;
  logic [7:0] mcCnt, mcCntNext;
  logic [2:0] drainCnt, drainCntNext;
  logic       timeoutHit;
  logic       pcEnRaw, ifidEnRaw, ifidFlushRaw, idexBubbleRaw, exHoldRaw;

  always_comb begin
    nextState     = curState;
    mcCntNext     = mcCnt;
    drainCntNext  = drainCnt;
    timeoutHit    = 1'b0;
    pcEnRaw       = 1'b1;
    ifidEnRaw     = 1'b1;
    ifidFlushRaw  = 1'b0;
    idexBubbleRaw = 1'b0;
    exHoldRaw     = 1'b0;
    case (curState)
      RUN: begin
        if (halt_req) begin
          pcEnRaw       = 1'b0;
          ifidEnRaw     = 1'b0;
          idexBubbleRaw = 1'b1;
          drainCntNext  = DRAIN_LOAD;
          nextState     = DRAIN;
        end else if (branch_taken_ex) begin
          ifidFlushRaw  = 1'b1;
          idexBubbleRaw = 1'b1;
        end else if (mc_start) begin
          pcEnRaw   = 1'b0;
          ifidEnRaw = 1'b0;
          exHoldRaw = 1'b1;
          mcCntNext = MC_LOAD;
          nextState = MCWAIT;
        end else if (hazard_stall) begin
          pcEnRaw       = 1'b0;
          ifidEnRaw     = 1'b0;
          idexBubbleRaw = 1'b1;
        end else if (jump_id) begin
          ifidFlushRaw = 1'b1;
        end
      end
      // halt_req is not looked at here; it takes effect in RUN after the exit cycle
      MCWAIT: begin
        if (mc_done) begin
          nextState = RUN;
        end else if (mcCnt == 8'd0) begin
          timeoutHit = 1'b1;
          nextState  = RUN;
        end else begin
          pcEnRaw   = 1'b0;
          ifidEnRaw = 1'b0;
          exHoldRaw = 1'b1;
          mcCntNext = mcCnt - 8'd1;
        end
      end
      DRAIN: begin
        pcEnRaw       = 1'b0;
        ifidEnRaw     = 1'b0;
        idexBubbleRaw = 1'b1;
        if (drainCnt == 3'd0) nextState = HALT;
        else drainCntNext = drainCnt - 3'd1;
      end
      HALT: begin
        pcEnRaw       = 1'b0;
        ifidEnRaw     = 1'b0;
        idexBubbleRaw = 1'b1;
        if (!halt_req) nextState = RUN;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState     <= RUN;
      mcCnt        <= 8'd0;
      drainCnt     <= 3'd0;
      mc_timeout   <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      curState <= nextState;
      mcCnt    <= mcCntNext;
      drainCnt <= drainCntNext;
      if (timeoutHit) mc_timeout <= 1'b1;
      if (!pcEnRaw && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // Reset overrides the Mealy outputs so the pipeline free-runs while held in reset
  assign pc_en       = pcEnRaw | ~rst_n;
  assign ifid_en     = ifidEnRaw | ~rst_n;
  assign ifid_flush  = ifidFlushRaw & rst_n;
  assign idex_bubble = idexBubbleRaw & rst_n;
  assign ex_hold     = exHoldRaw & rst_n;
  assign state       = curState;
  assign halted      = (curState == HALT);

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter MC_TIMEOUT, default 64: maximum cycles spent in MCWAIT, range 2..255.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: bubble cycles before HALT, range 1..7.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hazard_stall  input  1  load-use stall request from hazard detection.
REQ-006 branch_taken_ex  input  1  branch resolved taken in EX.
REQ-007 jump_id  input  1  jump decoded in ID.
REQ-008 mc_start  input  1  multi-cycle (SAD) op present in EX.
REQ-009 mc_done  input  1  multi-cycle op result valid.
REQ-010 halt_req  input  1  level request to halt the pipeline.
REQ-011 pc_en  output  1  PC register write enable.
REQ-012 ifid_en  output  1  IF/ID register write enable.
REQ-013 ifid_flush  output  1  clear IF/ID to NOP.
REQ-014 idex_bubble  output  1  force ID/EX control to zero.
REQ-015 ex_hold  output  1  freeze ID/EX and EX/MEM.
REQ-016 state  output  2  FSM state: RUN=0, MCWAIT=1, DRAIN=2, HALT=3.
REQ-017 halted  output  1  high exactly while state==HALT.
REQ-018 mc_timeout  output  1  sticky flag; set when an MC op times out.
REQ-019 stall_cycles  output  16  saturating count of cycles with pc_en==0.

Function
REQ-020 Control outputs SHALL be combinational from the registered state, the registered counter and the current inputs (Mealy); state, counters and flags SHALL be registered.
REQ-021 RUN defaults SHALL be pc_en=1, ifid_en=1, with ifid_flush, idex_bubble and ex_hold all 0.
REQ-022 RUN priority, highest first, SHALL be: halt_req, branch_taken_ex, mc_start, hazard_stall, jump_id.
REQ-023 RUN with halt_req: pc_en=0, ifid_en=0, idex_bubble=1; load drain counter with DRAIN_CYCLES-1; next state DRAIN.
REQ-024 RUN with branch_taken_ex: pc_en=1, ifid_flush=1, idex_bubble=1; stay in RUN. Any simultaneous hazard_stall, mc_start or jump_id is ignored.
REQ-025 RUN with mc_start: pc_en=0, ifid_en=0, ex_hold=1; load MC counter with MC_TIMEOUT-1; next state MCWAIT.
REQ-026 RUN with hazard_stall: pc_en=0, ifid_en=0, idex_bubble=1; stay in RUN. Single-cycle stall per assertion.
REQ-027 RUN with jump_id only: ifid_flush=1; enables stay 1.
REQ-028 MCWAIT without mc_done and counter nonzero: pc_en=0, ifid_en=0, ex_hold=1; decrement counter.
REQ-029 MCWAIT with mc_done: RUN defaults; next state RUN.
REQ-030 MCWAIT with counter==0 and no mc_done: RUN defaults; set mc_timeout; next state RUN.
REQ-031 MCWAIT SHALL ignore branch_taken_ex, hazard_stall, jump_id and mc_start.
REQ-032 halt_req asserted in MCWAIT SHALL be deferred until the cycle after the MCWAIT exit.
REQ-033 DRAIN: pc_en=0, ifid_en=0, idex_bubble=1; decrement counter; at counter==0, next state HALT.
REQ-034 DRAIN SHALL ignore all inputs except halt_req.
REQ-035 halt_req dropping during DRAIN SHALL complete the drain, then enter HALT for one cycle.
REQ-036 HALT: pc_en=0, ifid_en=0, idex_bubble=1; when halt_req==0, next state RUN.
REQ-037 stall_cycles SHALL increment on every cycle with pc_en==0 and saturate at 16'hFFFF.
REQ-038 mc_timeout SHALL clear only on reset.

Reset
REQ-039 rst_n low SHALL immediately force state=RUN, halted=0, mc_timeout=0, stall_cycles=0 and both counters 0.
REQ-040 While rst_n is low, outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, ex_hold=0.
REQ-041 Reset asserted mid-MCWAIT or mid-DRAIN SHALL abort the operation with no residual flags set.

Verification
REQ-042 Load-use: hazard_stall high for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle; stall_cycles=1; state stays 0.
REQ-043 Branch beats stall: branch_taken_ex=1 with hazard_stall=1 -> pc_en=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
REQ-044 MC op: mc_start, then mc_done on the 5th MCWAIT cycle -> ex_hold=1 for 5 cycles; state returns to 0; stall_cycles=5; mc_timeout=0.
REQ-045 Timeout, MC_TIMEOUT=4: mc_start, no mc_done -> exit after 4 MCWAIT cycles; mc_timeout=1 persists through subsequent RUN.
REQ-046 Halt: halt_req held -> 3 DRAIN cycles, then halted=1; halt_req dropped -> RUN next cycle, pc_en=1.
REQ-047 Reset mid-MCWAIT: rst_n low -> state=0 and pc_en=1 asynchronously, before any clock edge.
